// File: rtl/iq_upconverter_if.sv
// ============================================================================
// Module   : iq_upconverter_if
// Brief    : Sample/tuning/output bundle between the modulator side and the upconverter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iq_upconverter_if #(
  parameter int DW = 12,
  parameter int PW = 16,
  parameter int OW = 12
);
  logic                 en;
  logic                 in_valid;
  logic signed [DW-1:0] inphase;
  logic signed [DW-1:0] quadrature;
  logic        [PW-1:0] ftw;
  logic                 ftw_load;
  logic                 out_valid;
  logic signed [OW-1:0] out_sample;
  logic                 sat;

  modport master (
    output en, in_valid, inphase, quadrature, ftw, ftw_load,
    input  out_valid, out_sample, sat
  );

  modport slave (
    input  en, in_valid, inphase, quadrature, ftw, ftw_load,
    output out_valid, out_sample, sat
  );
endinterface

`default_nettype wire

// File: rtl/iq_upconverter.sv
// ============================================================================
// Module   : iq_upconverter
// Brief    : NCO mixer out = I*cos - Q*sin, 4-stage pipeline, round + saturate.
//            Optional phase dither via macro IQ_UPCONVERTER_PHASE_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_upconverter #(
  parameter int DW = 12,
  parameter int PW = 16,
  parameter int LW = 8,
  parameter int OW = 12
) (
  input  logic              dclk,
  input  logic              rstn,
  iq_upconverter_if.slave   bus
);

  localparam int              c_n      = 2 ** (LW - 2);
  localparam logic [LW-2:0]   c_nw     = (LW-1)'(c_n);
  localparam int              c_xw     = 2 * DW + 2;
  localparam logic signed [c_xw-1:0] c_half    = c_xw'(2 ** (DW - 2));
  localparam logic signed [c_xw-1:0] c_half_m1 = c_xw'(2 ** (DW - 2) - 1);
  localparam logic signed [c_xw-1:0] c_max     = c_xw'(2 ** (OW - 1) - 1);
  localparam logic signed [c_xw-1:0] c_min     = ~c_max;
  localparam logic signed [OW-1:0]   c_ymax    = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0]   c_ymin    = {1'b1, {(OW-1){1'b0}}};

  // Quarter-wave table round(2047*sin(pi/2*j/64)); contents assume LW=8, DW=12.
  localparam logic [DW-2:0] c_qtab [0:64] = '{
    11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
    11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
    11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
    11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
    11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
    11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
    11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
    11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
    11'd2047
  };

  logic                   w_accept;
  logic [LW-1:0]          w_p;
  logic [PW-1:0]          r_acc;
  logic [PW-1:0]          r_ftw;

  logic                   r_v1, r_v2, r_v3, r_vo;
  logic signed [DW-1:0]   r_i1, r_q1, r_i2, r_q2;
  logic [LW-1:0]          r_p1;
  logic signed [DW-1:0]   r_cos2, r_sin2;
  logic signed [2*DW-1:0] r_pi3, r_pq3;
  logic signed [OW-1:0]   r_out;
  logic                   r_sat;

  assign w_accept = bus.en & bus.in_valid;

`ifdef IQ_UPCONVERTER_PHASE_DITHER_EN
  logic [14:0]   r_lfsr;
  logic [PW-1:0] w_dith;

  assign w_dith = r_acc + PW'(r_lfsr[PW-LW-1:0]);
  assign w_p    = w_dith[PW-1:PW-LW];

  always_ff @(posedge dclk) begin
    if (!rstn) begin
      r_lfsr <= 15'h0001;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
    end
  end
`else
  assign w_p = r_acc[PW-1:PW-LW];
`endif

  // Quadrant folding of the quarter table into full-cycle sin/cos.
  logic [LW-2:0]        w_idx_k, w_idx_nk;
  logic signed [DW-1:0] w_tk, w_tnk, w_sin, w_cos;

  always_comb begin
    w_idx_k  = {1'b0, r_p1[LW-3:0]};
    w_idx_nk = c_nw - w_idx_k;
    w_tk     = $signed({1'b0, c_qtab[w_idx_k]});
    w_tnk    = $signed({1'b0, c_qtab[w_idx_nk]});
    w_sin    = w_tk;
    w_cos    = w_tnk;
    case (r_p1[LW-1:LW-2])
      2'd0: begin w_sin = w_tk;   w_cos = w_tnk;  end
      2'd1: begin w_sin = w_tnk;  w_cos = -w_tk;  end
      2'd2: begin w_sin = -w_tk;  w_cos = -w_tnk; end
      default: begin w_sin = -w_tnk; w_cos = w_tk; end
    endcase
  end

  // Difference, round half away from zero, then clip to the output range.
  logic signed [2*DW:0]   w_d;
  logic signed [c_xw-1:0] w_rnd, w_shift;
  logic signed [OW-1:0]   w_y;
  logic                   w_clip;

  always_comb begin
    w_d     = (2*DW+1)'(r_pi3) - (2*DW+1)'(r_pq3);
    w_rnd   = c_xw'(w_d) + (w_d[2*DW] ? c_half_m1 : c_half);
    w_shift = w_rnd >>> (DW - 1);
    w_clip  = 1'b0;
    w_y     = w_shift[OW-1:0];
    if (w_shift > c_max) begin
      w_y    = c_ymax;
      w_clip = 1'b1;
    end else if (w_shift < c_min) begin
      w_y    = c_ymin;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge dclk) begin
    if (!rstn) begin
      r_acc  <= '0;
      r_ftw  <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_vo   <= 1'b0;
      r_i1   <= '0;
      r_q1   <= '0;
      r_p1   <= '0;
      r_i2   <= '0;
      r_q2   <= '0;
      r_cos2 <= '0;
      r_sin2 <= '0;
      r_pi3  <= '0;
      r_pq3  <= '0;
      r_out  <= '0;
      r_sat  <= 1'b0;
    end else if (bus.en) begin
      if (bus.in_valid) begin
        r_acc <= r_acc + r_ftw;
      end
      if (bus.ftw_load) begin
        r_ftw <= bus.ftw;
      end
      r_v1   <= bus.in_valid;
      r_i1   <= bus.inphase;
      r_q1   <= bus.quadrature;
      r_p1   <= w_p;
      r_v2   <= r_v1;
      r_i2   <= r_i1;
      r_q2   <= r_q1;
      r_cos2 <= w_cos;
      r_sin2 <= w_sin;
      r_v3   <= r_v2;
      r_pi3  <= (2*DW)'(r_i2) * (2*DW)'(r_cos2);
      r_pq3  <= (2*DW)'(r_q2) * (2*DW)'(r_sin2);
      r_vo   <= r_v3;
      if (r_v3) begin
        r_out <= w_y;
        r_sat <= w_clip;
      end
    end
  end

  assign bus.out_valid  = r_vo;
  assign bus.out_sample = r_out;
  assign bus.sat        = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_iq_upconverter.sv
// ============================================================================
// Module   : tb_iq_upconverter
// Brief    : Directed stimulus against a latency/trig model of the upconverter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iq_upconverter;

  localparam int DW = 12;
  localparam int PW = 16;
  localparam int LW = 8;
  localparam int OW = 12;
  localparam real PI = 3.14159265358979323846;

  logic dclk = 1'b0;
  logic rstn;
  always #5 dclk = ~dclk;

  iq_upconverter_if #(.DW(DW), .PW(PW), .OW(OW)) bus ();

  iq_upconverter #(.DW(DW), .PW(PW), .LW(LW), .OW(OW)) dut (
    .dclk (dclk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int tgt;
    int val;
    bit s;
  } exp_t;

  exp_t  eq[$];
  int    got_val[$];
  bit    got_sat[$];
  int    total = 0;
  int    bad   = 0;

  logic [PW-1:0] m_acc = '0;
  logic [PW-1:0] m_ftw = '0;
  int            en_cnt = 0;
  bit            armed = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_fresh = 1'b0;
  int            m_sample = 0;
  bit            m_sat = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int round_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Expected mixer output straight from trig definitions and integer rounding.
  function automatic int model_out(input int i, input int q, input int p, output bit s);
    real    ang;
    longint c, sn, d, mag, r;
    ang = 2.0 * PI * real'(p) / real'(2 ** LW);
    c   = longint'(round_away(2047.0 * $cos(ang)));
    sn  = longint'(round_away(2047.0 * $sin(ang)));
    d   = longint'(i) * c - longint'(q) * sn;
    mag = (d < 0) ? -d : d;
    r   = (mag + 1024) / 2048;
    if (d < 0) r = -r;
    s = 1'b0;
    if (r > 2047)  begin r = 2047;  s = 1'b1; end
    if (r < -2048) begin r = -2048; s = 1'b1; end
    return int'(r);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge dclk);
      if (armed) begin
        chk("out_valid",  int'(bus.out_valid), int'(m_valid));
        chk("out_sample", int'($signed(bus.out_sample)), m_sample);
        chk("sat",        int'(bus.sat), int'(m_sat));
        if (m_valid && m_fresh) begin
          got_val.push_back(int'($signed(bus.out_sample)));
          got_sat.push_back(bus.sat);
          m_fresh = 1'b0;
        end
      end
      if (!rstn) begin
        m_acc = '0; m_ftw = '0; eq.delete();
        m_valid = 1'b0; m_sample = 0; m_sat = 1'b0; m_fresh = 1'b0;
        armed = 1'b1;
      end else if (bus.en) begin
        en_cnt++;
        if (bus.in_valid) begin
          e.tgt = en_cnt + 3;
          e.val = model_out(int'($signed(bus.inphase)), int'($signed(bus.quadrature)),
                            int'(m_acc[PW-1:PW-LW]), e.s);
          eq.push_back(e);
          m_acc = m_acc + m_ftw;
        end
        if (bus.ftw_load) m_ftw = bus.ftw;
        if (eq.size() > 0 && eq[0].tgt == en_cnt) begin
          m_valid = 1'b1; m_sample = eq[0].val; m_sat = eq[0].s; m_fresh = 1'b1;
          void'(eq.pop_front());
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    bus.in_valid   = 1'b1;
    bus.inphase    = DW'(i);
    bus.quadrature = DW'(q);
    tick();
    bus.in_valid   = 1'b0;
  endtask

  task automatic load_ftw(input logic [PW-1:0] w);
    bus.ftw      = w;
    bus.ftw_load = 1'b1;
    tick();
    bus.ftw_load = 1'b0;
  endtask

  task automatic clear_got();
    got_val.delete();
    got_sat.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (eq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (eq.size() != 0) chk("drain_timeout", eq.size(), 0);
    tick();
    tick();
  endtask

  task automatic lit(input string name, input int idx, input int val, input bit s);
    if (idx >= got_val.size()) begin
      chk(name, -99999, val);
    end else begin
      chk(name, got_val[idx], val);
      chk({name, "_sat"}, int'(got_sat[idx]), int'(s));
    end
  endtask

  initial begin
    rstn           = 1'b0;
    bus.en         = 1'b1;
    bus.in_valid   = 1'b0;
    bus.inphase    = '0;
    bus.quadrature = '0;
    bus.ftw        = '0;
    bus.ftw_load   = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;

    // DC carrier, I only: latency pinned at the 4th edge after accept.
    load_ftw(16'h0000);
    clear_got();
    for (int k = 0; k < 8; k++) begin
      send(1024, 0);
      chk("latency_valid", int'(bus.out_valid), (k >= 3) ? 1 : 0);
    end
    drain();
    chk("t1_count", got_val.size(), 8);
    for (int k = 0; k < 8; k++) lit("t1_dc", k, 1024, 1'b0);

    // DC carrier, Q only: sin(0) = 0.
    clear_got();
    repeat (4) send(0, 1024);
    drain();
    lit("t2_q_only", 0, 0, 1'b0);
    lit("t2_q_only", 3, 0, 1'b0);

    // Quarter-rate carrier, accumulator wraps every 4 samples.
    load_ftw(16'h4000);
    clear_got();
    repeat (8) send(1024, 0);
    drain();
    lit("t3_q0", 0, 1024, 1'b0);
    lit("t3_q1", 1, 0, 1'b0);
    lit("t3_q2", 2, -1024, 1'b0);
    lit("t3_q3", 3, 0, 1'b0);
    lit("t3_wrap", 4, 1024, 1'b0);
    lit("t3_wrap2", 6, -1024, 1'b0);

    // 45 degree step at full scale: positive saturation.
    load_ftw(16'h2000);
    clear_got();
    send(2047, -2047);
    send(2047, -2047);
    drain();
    lit("t4_phase0", 0, 2046, 1'b0);
    lit("t4_sat_pos", 1, 2047, 1'b1);

    // Stall with ignored valid/ftw_load, then gapped valids.
    load_ftw(16'h1000);
    clear_got();
    send(1024, 0);
    send(1024, 0);
    bus.en = 1'b0; bus.in_valid = 1'b1; bus.ftw = 16'h7777; bus.ftw_load = 1'b1;
    repeat (3) tick();
    bus.en = 1'b1; bus.in_valid = 1'b0; bus.ftw_load = 1'b0;
    send(1024, 0);
    tick();
    send(1024, 0);
    send(1024, 0);
    send(1024, 0);
    drain();
    chk("t5_count", got_val.size(), 6);
    lit("t5_p40", 0, 0, 1'b0);
    lit("t5_p50", 1, -392, 1'b0);
    lit("t5_p60", 2, -724, 1'b0);
    lit("t5_p70", 3, -946, 1'b0);
    lit("t5_p80", 4, -1024, 1'b0);
    lit("t5_p90", 5, -946, 1'b0);

    // ftw_load together with a sample: new word applies from the next sample.
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    load_ftw(16'h4000);
    clear_got();
    send(1024, 0);
    bus.ftw = 16'h2000; bus.ftw_load = 1'b1;
    send(1024, 0);
    bus.ftw_load = 1'b0;
    send(1024, 0);
    send(1024, 0);
    drain();
    lit("t6_s1", 0, 1024, 1'b0);
    lit("t6_s2", 1, 0, 1'b0);
    lit("t6_s3", 2, -1024, 1'b0);
    lit("t6_s4", 3, -724, 1'b0);

    // Reset mid-stream discards in-flight samples and clears phase/ftw.
    repeat (3) send(500, 300);
    bus.in_valid = 1'b1;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    bus.in_valid = 1'b0;
    chk("rst_valid",  int'(bus.out_valid), 0);
    chk("rst_sample", int'($signed(bus.out_sample)), 0);
    chk("rst_sat",    int'(bus.sat), 0);
    clear_got();
    repeat (4) send(1024, 0);
    drain();
    chk("t6_post_count", got_val.size(), 4);
    lit("t6_post_first", 0, 1024, 1'b0);
    lit("t6_post_last", 3, 1024, 1'b0);

    // Full phase sweep touching every table entry, varied amplitudes.
    load_ftw(16'h0100);
    clear_got();
    for (int k = 0; k < 256; k++) begin
      send(((k * 613) % 4096) - 2048, ((k * 1571 + 100) % 4096) - 2048);
    end
    drain();
    chk("t7_count", got_val.size(), 256);

    // Negative saturation at 45 degrees.
    load_ftw(16'h2000);
    clear_got();
    send(-2048, 2047);
    send(-2048, 2047);
    drain();
    lit("t8_phase0", 0, -2047, 1'b0);
    lit("t8_sat_neg", 1, -2048, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
